// File: rtl/arb_pkg.sv
// Shared types, default widths and a lane-select helper for the memory port arbiter.
package arb_pkg;

    typedef enum logic [1:0] {IDLE, XFER, DONE, HOLD} arb_state_t;

    localparam int unsigned DEF_NREQ    = 8;
    localparam int unsigned DEF_AWID    = 32;
    localparam int unsigned DEF_DWID    = 64;
    localparam int unsigned DEF_TMO     = 255;
    localparam int unsigned DEF_MAXLOCK = 16;

    localparam int unsigned LANE_W = 256;
    localparam int unsigned VEC_W  = 8 * LANE_W;

    // Lane idx (w bits wide) of a packed per-requester vector, zero-padded to LANE_W.
    function automatic logic [LANE_W-1:0] lane(input logic [VEC_W-1:0] vec,
                                               input logic [2:0]       idx,
                                               input int unsigned      w);
        logic [LANE_W-1:0] mask;
        mask = (LANE_W'(1) << w) - LANE_W'(1);
        return LANE_W'(vec >> (w * 32'(idx))) & mask;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner select: first set request at or after index rot, wrapping.
module rr_pick
    import arb_pkg::*;
#(
    parameter int unsigned NREQ = DEF_NREQ
) (
    input  logic [NREQ-1:0] req,
    input  logic [2:0]      rot,
    output logic [2:0]      winner_enc,
    output logic            any
);

    logic [2:0] idx;

    always_comb begin
        winner_enc = '0;
        any        = 1'b0;
        idx        = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            idx = 3'((32'(rot) + 32'(k)) % NREQ);
            if (!any && req[idx]) begin
                any        = 1'b1;
                winner_enc = idx;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory master port among cache/DMA requesters,
// with bounded locked bursts and an ack watchdog.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned NREQ    = DEF_NREQ,
    parameter int unsigned AWID    = DEF_AWID,
    parameter int unsigned DWID    = DEF_DWID,
    parameter int unsigned TMO     = DEF_TMO,
    parameter int unsigned MAXLOCK = DEF_MAXLOCK
) (
    input  logic                 rst,
    input  logic                 clk,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ-1:0]      lock_i,
    input  logic [NREQ-1:0]      we_i,
    input  logic [NREQ*AWID-1:0] adr_i,
    input  logic [NREQ*DWID-1:0] dat_i,
    output logic [NREQ-1:0]      ack_o,
    output logic [NREQ-1:0]      err_o,
    output logic [DWID-1:0]      dat_o,
    output logic                 m_cyc_o,
    output logic                 m_we_o,
    output logic [AWID-1:0]      m_adr_o,
    output logic [DWID-1:0]      m_dat_o,
    input  logic                 m_ack_i,
    input  logic [DWID-1:0]      m_dat_i,
    output logic [2:0]           owner_o,
    output logic                 busy_o
);

    localparam int unsigned TW = $clog2(TMO + 1);
    localparam int unsigned LW = (MAXLOCK > 1) ? $clog2(MAXLOCK) : 1;

    arb_state_t      state_q;
    logic [2:0]      rot_q;
    logic [2:0]      owner_q;
    logic [TW-1:0]   tmo_q;
    logic [LW-1:0]   lock_q;
    logic [2:0]      winner;
    logic            any_req;
    logic [2:0]      rot_nxt;
    logic [2:0]      load_idx;
    logic [AWID-1:0] load_adr;
    logic [DWID-1:0] load_dat;
    logic [NREQ-1:0] owner_oh;

    rr_pick #(
        .NREQ(NREQ)
    ) u_pick (
        .req       (req_i),
        .rot       (rot_q),
        .winner_enc(winner),
        .any       (any_req)
    );

    assign rot_nxt  = (winner == 3'(NREQ - 1)) ? 3'd0 : winner + 3'd1;
    // IDLE loads the fresh winner's inputs; HOLD reloads the locked owner's.
    assign load_idx = (state_q == IDLE) ? winner : owner_q;
    assign load_adr = AWID'(lane(VEC_W'(adr_i), load_idx, AWID));
    assign load_dat = DWID'(lane(VEC_W'(dat_i), load_idx, DWID));
    assign owner_oh = NREQ'(1) << owner_q;
    assign owner_o  = owner_q;
    assign busy_o   = (state_q != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rot_q   <= '0;
            owner_q <= '0;
            tmo_q   <= '0;
            lock_q  <= '0;
            ack_o   <= '0;
            err_o   <= '0;
            dat_o   <= '0;
            m_cyc_o <= 1'b0;
            m_we_o  <= 1'b0;
            m_adr_o <= '0;
            m_dat_o <= '0;
        end else begin
            ack_o <= '0;
            err_o <= '0;
            unique case (state_q)
                IDLE: begin
                    if (any_req) begin
                        owner_q <= winner;
                        rot_q   <= rot_nxt;
                        lock_q  <= '0;
                        tmo_q   <= '0;
                        m_cyc_o <= 1'b1;
                        m_we_o  <= we_i[load_idx];
                        m_adr_o <= load_adr;
                        m_dat_o <= load_dat;
                        state_q <= XFER;
                    end
                end
                XFER: begin
                    // Ack beats abort and timeout; a dropped request suppresses the error.
                    if (m_ack_i) begin
                        dat_o   <= m_dat_i;
                        ack_o   <= owner_oh;
                        m_cyc_o <= 1'b0;
                        state_q <= DONE;
                    end else if (!req_i[owner_q]) begin
                        m_cyc_o <= 1'b0;
                        state_q <= IDLE;
                    end else if (32'(tmo_q) == TMO) begin
                        err_o   <= owner_oh;
                        m_cyc_o <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                DONE: begin
                    if (lock_i[owner_q] && (32'(lock_q) < MAXLOCK - 1)) begin
                        lock_q  <= lock_q + LW'(1);
                        state_q <= HOLD;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                HOLD: begin
                    if (req_i[owner_q]) begin
                        tmo_q   <= '0;
                        m_cyc_o <= 1'b1;
                        m_we_o  <= we_i[load_idx];
                        m_adr_o <= load_adr;
                        m_dat_o <= load_dat;
                        state_q <= XFER;
                    end else if (!lock_i[owner_q]) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: cycle model plus directed scenarios.
module tb_mem_port_arbiter;

    localparam int unsigned NREQ    = 8;
    localparam int unsigned AWID    = 32;
    localparam int unsigned DWID    = 64;
    localparam int unsigned TMO     = 255;
    localparam int unsigned MAXLOCK = 16;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [NREQ-1:0]      req_i;
    logic [NREQ-1:0]      lock_i;
    logic [NREQ-1:0]      we_i;
    logic [NREQ*AWID-1:0] adr_i;
    logic [NREQ*DWID-1:0] dat_i;
    logic [NREQ-1:0]      ack_o;
    logic [NREQ-1:0]      err_o;
    logic [DWID-1:0]      dat_o;
    logic                 m_cyc_o;
    logic                 m_we_o;
    logic [AWID-1:0]      m_adr_o;
    logic [DWID-1:0]      m_dat_o;
    logic                 m_ack_i = 1'b0;
    logic [DWID-1:0]      m_dat_i = '0;
    logic [2:0]           owner_o;
    logic                 busy_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Requester agents: remaining transfers and whether they want a locked burst.
    int rem[NREQ];
    bit lockreq[NREQ];
    // Memory responder: ack after mem_lat cycles of m_cyc_o, or never if mem_en is 0.
    bit mem_en  = 1'b1;
    int mem_lat = 1;
    int mem_cnt = 0;
    int ack_log[$];
    int err_seen = 0;

    mem_port_arbiter #(
        .NREQ   (NREQ),
        .AWID   (AWID),
        .DWID   (DWID),
        .TMO    (TMO),
        .MAXLOCK(MAXLOCK)
    ) dut (
        .rst    (rst),
        .clk    (clk),
        .req_i  (req_i),
        .lock_i (lock_i),
        .we_i   (we_i),
        .adr_i  (adr_i),
        .dat_i  (dat_i),
        .ack_o  (ack_o),
        .err_o  (err_o),
        .dat_o  (dat_o),
        .m_cyc_o(m_cyc_o),
        .m_we_o (m_we_o),
        .m_adr_o(m_adr_o),
        .m_dat_o(m_dat_o),
        .m_ack_i(m_ack_i),
        .m_dat_i(m_dat_i),
        .owner_o(owner_o),
        .busy_o (busy_o)
    );

    initial forever #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < int'(NREQ); i++) begin
            req_i[i]  = rem[i] > 0;
            lock_i[i] = lockreq[i] && (rem[i] > 0);
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: phases 0=idle 1=transfer 2=turnaround 3=held by lock.
    int              e_phase, e_owner, e_rot, e_wait, e_burst;
    logic [NREQ-1:0] e_ack, e_err;
    logic [DWID-1:0] e_dat, e_mdat;
    logic [AWID-1:0] e_adr;
    logic            e_cyc, e_we;

    always @(posedge clk or posedge rst) begin : model
        int w;
        if (rst) begin
            e_phase <= 0; e_owner <= 0; e_rot <= 0; e_wait <= 0; e_burst <= 0;
            e_ack <= '0; e_err <= '0; e_dat <= '0; e_mdat <= '0; e_adr <= '0;
            e_cyc <= 1'b0; e_we <= 1'b0;
        end else begin
            e_ack <= '0;
            e_err <= '0;
            w = -1;
            if (e_phase == 0) begin
                for (int k = 0; k < int'(NREQ); k++)
                    if (w < 0 && req_i[(e_rot + k) % NREQ]) w = (e_rot + k) % NREQ;
                if (w >= 0) begin
                    e_rot   <= (w + 1) % NREQ;
                    e_burst <= 1;
                end
            end else if (e_phase == 3 && req_i[e_owner]) begin
                w = e_owner;
                e_burst <= e_burst + 1;
            end
            if (w >= 0) begin
                e_owner <= w;
                e_phase <= 1;
                e_wait  <= 1;
                e_cyc   <= 1'b1;
                e_we    <= we_i[w];
                e_adr   <= adr_i[w*AWID +: AWID];
                e_mdat  <= dat_i[w*DWID +: DWID];
            end else if (e_phase == 1) begin
                if (m_ack_i) begin
                    e_ack   <= NREQ'(1) << e_owner;
                    e_dat   <= m_dat_i;
                    e_cyc   <= 1'b0;
                    e_phase <= 2;
                end else if (!req_i[e_owner]) begin
                    e_cyc   <= 1'b0;
                    e_phase <= 0;
                end else if (e_wait == int'(TMO) + 1) begin
                    e_err   <= NREQ'(1) << e_owner;
                    e_cyc   <= 1'b0;
                    e_phase <= 0;
                end else begin
                    e_wait <= e_wait + 1;
                end
            end else if (e_phase == 2) begin
                e_phase <= (lock_i[e_owner] && e_burst < int'(MAXLOCK)) ? 3 : 0;
            end else if (e_phase == 3 && !lock_i[e_owner]) begin
                e_phase <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("ack_o", 128'(ack_o), 128'(e_ack));
            check("err_o", 128'(err_o), 128'(e_err));
            check("cyc/busy/owner", 128'({m_cyc_o, busy_o, owner_o}),
                  128'({e_cyc, e_phase != 0, 3'(e_owner)}));
            check("m_we/adr/dat", 128'({m_we_o, m_adr_o, m_dat_o}), 128'({e_we, e_adr, e_mdat}));
            check("dat_o", 128'(dat_o), 128'(e_dat));
            check("ack/err onehot", 128'(((ack_o | err_o) & ((ack_o | err_o) - 1'b1)) != 0
                                         || (ack_o & err_o) != 0), 128'(0));
            for (int i = 0; i < int'(NREQ); i++)
                if (ack_o[i]) ack_log.push_back(i);
            if (err_o != 0) err_seen++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < int'(NREQ); i++)
            if ((ack_o[i] || err_o[i]) && rem[i] > 0) rem[i]--;
        if (m_cyc_o) mem_cnt++;
        else mem_cnt = 0;
        m_ack_i = mem_en && m_cyc_o && (mem_cnt == mem_lat);
        m_dat_i = m_ack_i ? {~m_adr_o, m_adr_o} : '0;
    endtask

    function automatic bit pending();
        for (int i = 0; i < int'(NREQ); i++)
            if (rem[i] > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic wait_quiet(input string name, input int budget);
        int n;
        n = 0;
        while ((busy_o || pending()) && n < budget) begin
            tick();
            n++;
        end
        check({name, " settles"}, 128'(busy_o || pending()), 128'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int exp_fair[9] = '{3, 4, 5, 6, 7, 0, 1, 2, 3};
        for (int i = 0; i < int'(NREQ); i++) begin
            rem[i]     = 0;
            lockreq[i] = 1'b0;
            we_i[i]    = i[0];
            adr_i[i*AWID +: AWID] = 32'h1000 + 32'(((i + 6) % 8) * 16);
            dat_i[i*DWID +: DWID] = {32'hA5A5_0000 + 32'(i), 32'(i)};
        end

        #1 rst = 1'b1;
        #1;
        check("reset outputs", 128'({ack_o, err_o, m_cyc_o, busy_o, owner_o, m_adr_o}), 128'(0));
        check("reset dat_o", 128'(dat_o), 128'(0));
        tick(); tick();
        rst = 1'b0;
        tick();

        // Single requester 2, memory acks on the third transfer cycle.
        mem_lat = 3;
        rem[2]  = 1;
        tick();
        check("t1 cyc1 m_cyc_o", 128'(m_cyc_o), 128'(1));
        check("t1 m_adr_o", 128'(m_adr_o), 128'(32'h1000));
        check("t1 owner_o", 128'(owner_o), 128'(2));
        tick(); tick();
        check("t1 cyc3 state", 128'({m_cyc_o, ack_o}), 128'({1'b1, 8'h00}));
        tick();
        check("t1 cyc4 ack_o", 128'(ack_o), 128'(8'h04));
        check("t1 cyc4 m_cyc_o", 128'(m_cyc_o), 128'(0));
        check("t1 dat_o", 128'(dat_o), 128'(64'hFFFF_EFFF_0000_1000));
        wait_quiet("t1", 20);

        // Fairness: everyone asks twice; rot starts at 3 after the grant to 2.
        mem_lat = 1;
        ack_log.delete();
        for (int i = 0; i < int'(NREQ); i++) rem[i] = 2;
        wait_quiet("t2", 200);
        check("t2 ack count", 128'(ack_log.size()), 128'(16));
        for (int i = 0; i < 9; i++) check("t2 grant order", 128'(ack_log[i]), 128'(exp_fair[i]));

        // Locked burst of 4 from requester 5 while 1 waits.
        ack_log.delete();
        lockreq[5] = 1'b1;
        rem[5]     = 4;
        tick();
        rem[1] = 1;
        wait_quiet("t3a", 100);
        check("t3a ack count", 128'(ack_log.size()), 128'(5));
        for (int i = 0; i < 4; i++) check("t3a burst owner", 128'(ack_log[i]), 128'(5));
        check("t3a then req1", 128'(ack_log[4]), 128'(1));

        // Lock held for 20 transfers: released after MAXLOCK, 1 gets in, then the rest.
        ack_log.delete();
        rem[5] = 20;
        tick();
        rem[1] = 1;
        wait_quiet("t3b", 300);
        check("t3b ack count", 128'(ack_log.size()), 128'(21));
        for (int i = 0; i < 21; i++)
            check("t3b burst order", 128'(ack_log[i]), 128'((i == int'(MAXLOCK)) ? 1 : 5));
        lockreq[5] = 1'b0;

        // Timeout on requester 3.
        mem_en = 1'b0;
        rem[3] = 1;
        tick();
        check("t4 cyc1 m_cyc_o", 128'(m_cyc_o), 128'(1));
        repeat (TMO) tick();
        check("t4 last wait cycle", 128'({err_o, m_cyc_o}), 128'({8'h00, 1'b1}));
        tick();
        check("t4 err_o", 128'(err_o), 128'(8'h08));
        check("t4 cyc/busy/ack", 128'({m_cyc_o, busy_o, ack_o}), 128'(0));
        wait_quiet("t4", 20);

        // Abort: requester 6 drops its request mid-transfer.
        ack_log.delete();
        rem[6] = 1;
        tick();
        check("t5a owner_o", 128'({m_cyc_o, owner_o}), 128'({1'b1, 3'd6}));
        tick(); tick();
        rem[6] = 0;
        tick();
        check("t5a abort", 128'({m_cyc_o, busy_o, ack_o, err_o}), 128'(0));
        check("t5a no ack", 128'(ack_log.size()), 128'(0));

        // Ack lands exactly on the timeout cycle.
        mem_en   = 1'b1;
        mem_lat  = int'(TMO) + 1;
        err_seen = 0;
        rem[4]   = 1;
        wait_quiet("t5b", 400);
        check("t5b ack count", 128'(ack_log.size()), 128'(1));
        check("t5b ack owner", 128'(ack_log[0]), 128'(4));
        check("t5b no err", 128'(err_seen), 128'(0));

        // Async reset during a transfer, then a fresh grant.
        mem_en = 1'b0;
        rem[3] = 1;
        tick(); tick(); tick();
        #2 rst = 1'b1;
        #1;
        check("t6 reset m_cyc_o", 128'(m_cyc_o), 128'(0));
        check("t6 reset outputs", 128'({ack_o, err_o, busy_o, owner_o, m_we_o, m_adr_o}), 128'(0));
        check("t6 reset data", 128'({dat_o, m_dat_o}), 128'(0));
        rem[3] = 0;
        tick(); tick();
        rst = 1'b0;
        mem_en  = 1'b1;
        mem_lat = 1;
        ack_log.delete();
        rem[7]  = 1;
        tick();
        check("t6 owner after reset", 128'({m_cyc_o, owner_o}), 128'({1'b1, 3'd7}));
        check("t6 m_adr_o", 128'(m_adr_o), 128'(32'h1050));
        wait_quiet("t6", 20);
        check("t6 ack owner", 128'(ack_log.size() == 1 && ack_log[0] == 7), 128'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
